// File: rtl/fanctrl_pkg.sv
// Shared types and helpers for the fan-controller PI sequencer and its
// sample-tick divider.
package fanctrl_pkg;

    localparam int ADC_BITWIDTH_DEF = 4;
    localparam int COEF_W_DEF       = 8;
    localparam int ERR_W_DEF        = ADC_BITWIDTH_DEF + 1;
    localparam int PROD_W_DEF       = COEF_W_DEF + ERR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_P,
        ST_MUL_I,
        ST_INTEG,
        ST_SUM,
        ST_OUT
    } state_e;

    // Clamp to the signed control-word range [-2^bw, 2^bw - 1].
    function automatic int sat_out(input int v, input int bw);
        int hi;
        int lo;
        hi = (1 << bw) - 1;
        lo = -(1 << bw);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fanctrl_pid_sequencer_if.sv
// Shared-multiplier handshake between the PI sequencer (master) and the MAC
// unit (slave).
interface fanctrl_pid_sequencer_if
    import fanctrl_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int ERR_W  = ERR_W_DEF,
    parameter int PROD_W = PROD_W_DEF
);
    logic                     mac_req;
    logic signed [COEF_W-1:0] mac_a;
    logic signed [ERR_W-1:0]  mac_b;
    logic                     mac_ack;
    logic signed [PROD_W-1:0] mac_prod;

    modport master (output mac_req, mac_a, mac_b, input mac_ack, mac_prod);
    modport slave  (input mac_req, mac_a, mac_b, output mac_ack, mac_prod);
endinterface

// File: rtl/fanctrl_sample_tick.sv
// Free-running 0..CLK_DIV counter; tick is high for the one cycle the count
// sits at CLK_DIV. Shared with the display refresh logic.
module fanctrl_sample_tick #(
    parameter int CLK_DIV = 999
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        tick    = (count_q == CNT_W'(CLK_DIV));
        count_d = tick ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: rtl/fanctrl_pid_sequencer.sv
// PI-loop sequencer: samples the error on each tick, runs P and I products
// through a shared multiplier, updates the integrator and publishes a
// saturated control word. Define FANCTRL_ANTIWINDUP_EN for conditional integration.
module fanctrl_pid_sequencer
    import fanctrl_pkg::*;
#(
    parameter int ADC_BITWIDTH = ADC_BITWIDTH_DEF,
    parameter int CLK_DIV      = 999,
    parameter int COEF_W       = COEF_W_DEF,
    parameter int FRAC_BITS    = 4,
    parameter int KP           = 16,
    parameter int KI           = 4,
    parameter int INT_W        = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADC_BITWIDTH-1:0]       adc_val,
    input  logic [ADC_BITWIDTH-1:0]       set_val,
    fanctrl_pid_sequencer_if.master       mac,
    output logic signed [ADC_BITWIDTH:0]  pid_out,
    output logic                          pid_valid,
    output logic                          busy,
    output logic                          overrun
);
    localparam int ERR_W  = ADC_BITWIDTH + 1;
    localparam int PROD_W = COEF_W + ERR_W;
    localparam int I_LIM  = (1 << (INT_W - 1)) - 1;
    localparam logic signed [ERR_W-1:0] OUT_MAX = {1'b0, {ADC_BITWIDTH{1'b1}}};
    localparam logic signed [ERR_W-1:0] OUT_MIN = {1'b1, {ADC_BITWIDTH{1'b0}}};

    state_e                   state_q, state_d;
    logic signed [ERR_W-1:0]  err_q, err_d;
    logic signed [PROD_W-1:0] p_q, p_d, iprod_q, iprod_d;
    logic signed [INT_W-1:0]  iacc_q, iacc_d;
    logic signed [ERR_W-1:0]  pid_out_q, pid_out_d;
    logic                     overrun_q, overrun_d;
    logic                     tick;
    logic                     hold;
    int                       acc_sum;
    int                       ctl_sum;

    fanctrl_sample_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        mac.mac_req = (state_q == ST_MUL_P) || (state_q == ST_MUL_I);
        mac.mac_a   = (state_q == ST_MUL_P) ? COEF_W'(KP) :
                      (state_q == ST_MUL_I) ? COEF_W'(KI) : '0;
        mac.mac_b   = mac.mac_req ? err_q : '0;
        busy        = (state_q != ST_IDLE);
        pid_valid   = (state_q == ST_OUT);
        pid_out     = pid_out_q;
        overrun     = overrun_q;
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        p_d       = p_q;
        iprod_d   = iprod_q;
        iacc_d    = iacc_q;
        pid_out_d = pid_out_q;
        overrun_d = overrun_q | (tick & (state_q != ST_IDLE));
        acc_sum   = 0;
        ctl_sum   = 0;
`ifdef FANCTRL_ANTIWINDUP_EN
        // Freeze integration while the output is pinned and Iprod pushes further out.
        hold = ((pid_out_q == OUT_MAX) && !iprod_q[PROD_W-1] && (iprod_q != '0)) ||
               ((pid_out_q == OUT_MIN) &&  iprod_q[PROD_W-1]);
`else
        hold = 1'b0;
`endif
        case (state_q)
            ST_IDLE: if (tick) begin
                err_d   = $signed({1'b0, set_val}) - $signed({1'b0, adc_val});
                state_d = ST_MUL_P;
            end
            ST_MUL_P: if (mac.mac_ack) begin
                p_d     = mac.mac_prod;
                state_d = ST_MUL_I;
            end
            ST_MUL_I: if (mac.mac_ack) begin
                iprod_d = mac.mac_prod;
                state_d = ST_INTEG;
            end
            ST_INTEG: begin
                acc_sum = int'(iacc_q) + int'(iprod_q);
                if (acc_sum > I_LIM)       acc_sum = I_LIM;
                else if (acc_sum < -I_LIM) acc_sum = -I_LIM;
                if (!hold) iacc_d = acc_sum[INT_W-1:0];
                state_d = ST_SUM;
            end
            ST_SUM: begin
                ctl_sum   = sat_out((int'(p_q) + int'(iacc_q)) >>> FRAC_BITS, ADC_BITWIDTH);
                pid_out_d = ctl_sum[ERR_W-1:0];
                state_d   = ST_OUT;
            end
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_q     <= '0;
            p_q       <= '0;
            iprod_q   <= '0;
            iacc_q    <= '0;
            pid_out_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            p_q       <= p_d;
            iprod_q   <= iprod_d;
            iacc_q    <= iacc_d;
            pid_out_q <= pid_out_d;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_fanctrl_pid_sequencer.sv
// Randomized self-checking bench for fanctrl_pid_sequencer: a PI instance with
// variable-latency MAC and a P-only instance for saturation and overrun.
module tb_fanctrl_pid_sequencer;
    localparam int CW = 8, EW = 5, PW = 13, FRAC = 4, I_LIM = 2047;
    localparam int DIV_M = 13, PER_M = 14, KP_M = 16, KI_M = 4;
    localparam int DIV_A = 5,  PER_A = 6,  KP_A = 32, KI_A = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fanctrl_pid_sequencer_if #(.COEF_W(CW), .ERR_W(EW), .PROD_W(PW)) m_if ();
    fanctrl_pid_sequencer_if #(.COEF_W(CW), .ERR_W(EW), .PROD_W(PW)) a_if ();

    logic [3:0]        adc_m, set_m, adc_a, set_a;
    logic signed [4:0] out_m, out_a;
    logic              vld_m, busy_m, ovr_m, vld_a, busy_a, ovr_a;

    int total = 0, bad = 0;
    int cyc;
    int dp_m = 0, di_m = 0, dly_a = 0;
    int wc_m, wc_a;
    logic ph_m;
    int iacc_m = 0, last_m = 0;

    fanctrl_pid_sequencer #(.ADC_BITWIDTH(4), .CLK_DIV(DIV_M), .COEF_W(CW), .FRAC_BITS(FRAC),
                            .KP(KP_M), .KI(KI_M), .INT_W(12)) u_main (
        .clk(clk), .rst(rst), .adc_val(adc_m), .set_val(set_m), .mac(m_if.master),
        .pid_out(out_m), .pid_valid(vld_m), .busy(busy_m), .overrun(ovr_m));

    fanctrl_pid_sequencer #(.ADC_BITWIDTH(4), .CLK_DIV(DIV_A), .COEF_W(CW), .FRAC_BITS(FRAC),
                            .KP(KP_A), .KI(KI_A), .INT_W(12)) u_aux (
        .clk(clk), .rst(rst), .adc_val(adc_a), .set_val(set_a), .mac(a_if.master),
        .pid_out(out_a), .pid_valid(vld_a), .busy(busy_a), .overrun(ovr_a));

    function automatic logic signed [PW-1:0] mulp(input logic signed [CW-1:0] a,
                                                  input logic signed [EW-1:0] b);
        int r;
        r = int'(a) * int'(b);
        return r[PW-1:0];
    endfunction

    // MAC models: ack after a programmable number of wait cycles per request.
    always @(posedge clk or posedge rst) begin
        if (rst) begin wc_m <= 0; ph_m <= 1'b0; end
        else if (!m_if.mac_req) begin wc_m <= 0; ph_m <= 1'b0; end
        else if (m_if.mac_ack) begin wc_m <= 0; ph_m <= ~ph_m; end
        else wc_m <= wc_m + 1;
    end
    assign m_if.mac_ack  = m_if.mac_req && (wc_m == (ph_m ? di_m : dp_m));
    assign m_if.mac_prod = mulp(m_if.mac_a, m_if.mac_b);

    always @(posedge clk or posedge rst) begin
        if (rst) wc_a <= 0;
        else if (!a_if.mac_req || a_if.mac_ack) wc_a <= 0;
        else wc_a <= wc_a + 1;
    end
    assign a_if.mac_ack  = a_if.mac_req && (wc_a == dly_a);
    assign a_if.mac_prod = mulp(a_if.mac_a, a_if.mac_b);

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int sat5(input int v);
        return (v > 15) ? 15 : (v < -16) ? -16 : v;
    endfunction

    // Reference PI step straight from the control law.
    task automatic model_main(input int e, output int o);
        int ip;
        bit skip;
        ip   = KI_M * e;
        skip = 1'b0;
`ifdef FANCTRL_ANTIWINDUP_EN
        skip = (last_m == 15 && ip > 0) || (last_m == -16 && ip < 0);
`endif
        if (!skip) begin
            iacc_m = iacc_m + ip;
            if (iacc_m > I_LIM) iacc_m = I_LIM;
            if (iacc_m < -I_LIM) iacc_m = -I_LIM;
        end
        o = sat5((KP_M * e + iacc_m) >>> FRAC);
        last_m = o;
    endtask

    task automatic run_sample(input int adc, input int set, input int dp, input int di);
        int e, o, ex, prev;
        bit found;
        logic signed [7:0] ea;
        logic signed [4:0] eb, eo, ep;
        adc_m = adc[3:0]; set_m = set[3:0]; dp_m = dp; di_m = di;
        prev = last_m; ep = 5'(prev);
        e = set - adc; model_main(e, o); ex = 5 + dp + di;
        eb = 5'(e); eo = 5'(o);
        found = 1'b0;
        for (int k = 0; k <= PER_M; k++) begin
            if (((cyc + 1) % PER_M) == 0) begin found = 1'b1; break; end
            total++;
            if (busy_m !== 1'b0 || vld_m !== 1'b0)
                begin bad++; $display("FAIL idle busy=%b valid=%b want 0 0", busy_m, vld_m); end
            total++;
            if (out_m !== ep)
                begin bad++; $display("FAIL hold pid_out=%0d want %0d", out_m, ep); end
            @(negedge clk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL tick_wait got no tick want tick within %0d", PER_M); end
        @(negedge clk);
        for (int k = 1; k <= ex + 1; k++) begin
            total++;
            if (m_if.mac_req !== (k <= ex - 3))
                begin bad++; $display("FAIL mac_req cyc%0d got=%b want=%b", k, m_if.mac_req, (k <= ex - 3)); end
            if (k <= ex - 3) begin
                ea = (k <= 1 + dp) ? 8'(KP_M) : 8'(KI_M);
                total++;
                if (m_if.mac_a !== ea || m_if.mac_b !== eb)
                    begin bad++; $display("FAIL mac_ops cyc%0d got a=%0d b=%0d want a=%0d b=%0d", k, m_if.mac_a, m_if.mac_b, ea, eb); end
            end
            total++;
            if (vld_m !== (k == ex))
                begin bad++; $display("FAIL pid_valid cyc%0d got=%b want=%b", k, vld_m, (k == ex)); end
            if (k == ex) begin
                total++;
                if (out_m !== eo)
                    begin bad++; $display("FAIL pid_out e=%0d got=%0d want=%0d", e, out_m, eo); end
            end
            if (k <= ex) @(negedge clk);
        end
    endtask

    task automatic aux_sample(input int adc, input int set);
        int e;
        logic signed [4:0] eo;
        adc_a = adc[3:0]; set_a = set[3:0];
        e = set - adc;
        eo = 5'(sat5((KP_A * e + KI_A * e * 0) >>> FRAC));
        for (int k = 0; k < PER_A; k++) begin
            if (((cyc + 1) % PER_A) == 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        total++;
        if (vld_a !== 1'b0) begin bad++; $display("FAIL aux_early_valid got=%b want=0", vld_a); end
        @(negedge clk);
        total++;
        if (vld_a !== 1'b1 || out_a !== eo)
            begin bad++; $display("FAIL aux_out e=%0d got valid=%b out=%0d want 1 %0d", e, vld_a, out_a, eo); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adc_m = '0; set_m = '0; adc_a = '0; set_a = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({m_if.mac_req, m_if.mac_a, m_if.mac_b, out_m, vld_m, busy_m, ovr_m} !== '0)
            begin bad++; $display("FAIL reset_main got req=%b a=%0d b=%0d out=%0d v=%b b=%b o=%b want all 0",
                                  m_if.mac_req, m_if.mac_a, m_if.mac_b, out_m, vld_m, busy_m, ovr_m); end
        total++;
        if ({a_if.mac_req, a_if.mac_a, a_if.mac_b, out_a, vld_a, busy_a, ovr_a} !== '0)
            begin bad++; $display("FAIL reset_aux got req=%b out=%0d v=%b b=%b o=%b want all 0",
                                  a_if.mac_req, out_a, vld_a, busy_a, ovr_a); end
        rst = 1'b0;
        iacc_m = 0; last_m = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_sample($urandom_range(15), $urandom_range(15), $urandom_range(3), $urandom_range(3));
    endtask

    task automatic test_windup();
        for (int i = 0; i < 40; i++) run_sample(5, 7, $urandom_range(1), $urandom_range(1));
        for (int i = 0; i < 3; i++)  run_sample(7, 5, 0, 0);
    endtask

    task automatic test_saturation();
        aux_sample(0, 15);
        aux_sample(15, 0);
        for (int i = 0; i < 6; i++) aux_sample($urandom_range(15), $urandom_range(15));
    endtask

    task automatic test_overrun();
        int nv;
        logic signed [7:0] ea;
        adc_a = 4'd3; set_a = 4'd9;
        for (int k = 0; k < PER_A; k++) begin
            if (((cyc + 1) % PER_A) == 0) break;
            @(negedge clk);
        end
        total++;
        if (ovr_a !== 1'b0) begin bad++; $display("FAIL overrun_pre got=%b want=0", ovr_a); end
        dly_a = 10; nv = 0;
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            total++;
            if (a_if.mac_req !== (k <= 22))
                begin bad++; $display("FAIL ovr_req cyc%0d got=%b want=%b", k, a_if.mac_req, (k <= 22)); end
            if (k <= 22) begin
                ea = (k <= 11) ? 8'(KP_A) : 8'(KI_A);
                total++;
                if (a_if.mac_a !== ea || a_if.mac_b !== 5'sd6)
                    begin bad++; $display("FAIL ovr_ops cyc%0d got a=%0d b=%0d want a=%0d b=6", k, a_if.mac_a, a_if.mac_b, ea); end
            end
            if (vld_a === 1'b1) begin
                nv++;
                total++;
                if (k != 25 || out_a !== 5'sd12)
                    begin bad++; $display("FAIL ovr_valid cyc%0d out=%0d want cyc25 out=12", k, out_a); end
            end
        end
        dly_a = 0;
        total++;
        if (nv != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", nv); end
        total++;
        if (ovr_a !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", ovr_a); end
        aux_sample(4, 4);
        total++;
        if (ovr_a !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", ovr_a); end
    endtask

    task automatic test_reset_mid();
        adc_m = 4'd2; set_m = 4'd11; dp_m = 3; di_m = 3;
        for (int k = 0; k <= PER_M; k++) begin
            if (((cyc + 1) % PER_M) == 0) break;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        total++;
        if (m_if.mac_req !== 1'b1 || m_if.mac_a !== 8'(KI_M))
            begin bad++; $display("FAIL pre_abort got req=%b a=%0d want 1 %0d", m_if.mac_req, m_if.mac_a, KI_M); end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({m_if.mac_req, m_if.mac_a, m_if.mac_b, out_m, vld_m, busy_m, ovr_m} !== '0)
            begin bad++; $display("FAIL async_reset got req=%b a=%0d b=%0d out=%0d v=%b b=%b want all 0",
                                  m_if.mac_req, m_if.mac_a, m_if.mac_b, out_m, vld_m, busy_m); end
        total++;
        if (ovr_a !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b want=0", ovr_a); end
        @(negedge clk);
        rst = 1'b0;
        iacc_m = 0; last_m = 0;
        for (int i = 0; i < 5; i++)
            run_sample($urandom_range(15), $urandom_range(15), $urandom_range(3), $urandom_range(3));
    endtask

    initial begin
        test_reset();
        test_random();
        test_windup();
        test_saturation();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fanctrl_pid_sequencer.md
# fanctrl_pid_sequencer

Sample-rate scheduler and sequencer for the fan controller's PI loop. It divides the system clock into a sample tick and latches the ADC and setpoint nibbles. It then drives one shared multiplier through the P and I products, maintains the integrator, and publishes a saturated signed control word, which feeds the PWM generator and the 7-segment display path.

## Interface
- ADC_BITWIDTH, 4, width of ADC and setpoint inputs; error and output are ADC_BITWIDTH+1 signed
- CLK_DIV, 999, sample period is CLK_DIV+1 clock cycles; legal minimum 5
- COEF_W, 8, signed coefficient width
- FRAC_BITS, 4, fractional bits of KP/KI (16 = 1.0)
- KP, 16, proportional coefficient, signed COEF_W
- KI, 4, integral coefficient, signed COEF_W
- INT_W, 12, signed integrator width
- clk  in  1  system clock (1 MHz nominal)
- rst  in  1  reset, asynchronous, active-high
- adc_val  in  ADC_BITWIDTH  measured value, unsigned
- set_val  in  ADC_BITWIDTH  setpoint, unsigned
- mac_req  out  1  multiplier request
- mac_a  out  COEF_W  signed coefficient operand
- mac_b  out  ADC_BITWIDTH+1  signed error operand
- mac_ack  in  1  multiplier done; mac_prod valid in the same cycle
- mac_prod  in  COEF_W+ADC_BITWIDTH+1  signed product
- pid_out  out  ADC_BITWIDTH+1  signed control output
- pid_valid  out  1  one-cycle pulse on pid_out update
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  sticky; a tick arrived while busy

## Operation
- Tick counter runs 0..CLK_DIV and wraps; tick = (count == CLK_DIV). It is free-running and unaffected by FSM state.
- FSM states: IDLE, MUL_P, MUL_I, INTEG, SUM, OUT.
- IDLE: on tick, capture e = set_val − adc_val (signed ADC_BITWIDTH+1, range −15..15 for 4 bits) and go to MUL_P.
- MUL_P: mac_req=1, mac_a=KP, mac_b=e. On mac_ack, store P = mac_prod and go to MUL_I.
- MUL_I: same as MUL_P with mac_a=KI. On mac_ack, store Iprod and go to INTEG.
- INTEG: I_acc ← clamp(I_acc + Iprod, ±(2^(INT_W−1)−1)). Go to SUM.
- SUM: s = (P + I_acc) >>> FRAC_BITS, arithmetic shift, computed at INT_W+1 bits. Saturate s to [−2^ADC_BITWIDTH, 2^ADC_BITWIDTH−1] (−16..15) and register it into pid_out. Go to OUT.
- OUT: pid_valid=1, then IDLE.
- Handshake: mac_a and mac_b are stable while mac_req is high. mac_req drops in the cycle after the ack cycle. Zero-wait ack (same cycle as req rising) is legal. mac_ack while mac_req is low is ignored.
- Tick while busy: the tick is dropped, overrun is set, and the sequence in progress completes. Only rst clears overrun.
- pid_out holds its value between updates.

## Timing
- Reset values: mac_req, mac_a, mac_b, pid_out, pid_valid, busy, overrun all 0. I_acc=0, count=0, state IDLE.
- rst asserted mid-sequence aborts immediately: mac_req low, integrator cleared, no pid_valid.
- With zero-wait MAC, pid_valid is high in the 5th cycle after the tick edge. Each MAC wait cycle adds 1.
- pid_out changes on the same edge that raises pid_valid.
- First tick after reset release occurs CLK_DIV+1 edges later.

## Configuration
- FANCTRL_ANTIWINDUP_EN defined: INTEG skips the accumulate when the last registered pid_out is at +max and Iprod > 0, or at −min and Iprod < 0 (conditional integration). The clamp still applies.
- Not defined: the accumulate is unconditional; only the ±clamp limits windup.

## Structure
- Shared package fanctrl_pkg holds:
  - the FSM state enum;
  - ADC_BITWIDTH default and derived widths (error, product, output);
  - a saturate function for the output range.
- Sub-module fanctrl_sample_tick contains the CLK_DIV counter and tick output, and is reused by the display refresh logic.

## Test plan
- P only: KP=16, KI=0, adc=7, set=5, zero-wait MAC → pid_out=−2. pid_valid is one cycle, 5 cycles after tick.
- Integrator: KP=0, KI=8, adc=5, set=7 → I_acc grows by 16 per sample. pid_out = 1,2,3,… and holds at 15.
- Saturation: KP=32, set=15, adc=0 → 15. Then set=0, adc=15 → −16.
- MAC wait: ack delayed 3 cycles per request → mac_a/mac_b stable throughout, mac_req drops after ack, pid_valid at cycle 11.
- Overrun: CLK_DIV=5, ack delayed 10 → overrun=1, skipped tick produces no extra pid_valid. Reset clears overrun.
- Reset mid-MUL_I: rst pulse → all outputs 0 asynchronously. Next valid output follows a fresh tick with I_acc starting from 0.
- With FANCTRL_ANTIWINDUP_EN: rerun the integrator case, then swap to adc=7, set=5 → pid_out leaves 15 on the first negative sample.
